// File: rtl/inst_encoder_if.sv
// Request and instruction-memory write bundle for the RV32I instruction encoder.
// The encoder takes the slave side; the program source takes the master side.
interface inst_encoder_if #(
  parameter int ADDR_WIDTH = 8
) ();
  logic                  start;
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            in_type;
  logic [4:0]            in_rd;
  logic [4:0]            in_rs1;
  logic [4:0]            in_rs2;
  logic [2:0]            in_funct3;
  logic [6:0]            in_funct7;
  logic [31:0]           in_imm;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic [ADDR_WIDTH:0]   word_count;
  logic                  full;
  logic                  err;
  logic [1:0]            err_code;

  modport slave (
    input  start, in_valid, in_type, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    output in_ready, wr_en, wr_addr, wr_data, word_count, full, err, err_code
  );

  modport master (
    output start, in_valid, in_type, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    input  in_ready, wr_en, wr_addr, wr_data, word_count, full, err, err_code
  );
endinterface

// File: rtl/inst_encoder.sv
// Assembles RV32I instruction words from field descriptions and writes them
// sequentially into instruction memory; rejected requests raise a one-cycle err.
module inst_encoder #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0,
  parameter int MAX_WORDS  = 256
) (
  input logic           clk,
  input logic           rstn,
  inst_encoder_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   MAXW = (ADDR_WIDTH+1)'(MAX_WORDS);

  localparam logic [2:0] T_R      = 3'd0;
  localparam logic [2:0] T_IALU   = 3'd1;
  localparam logic [2:0] T_LOAD   = 3'd2;
  localparam logic [2:0] T_STORE  = 3'd3;
  localparam logic [2:0] T_BRANCH = 3'd4;
  localparam logic [2:0] T_JAL    = 3'd5;
  localparam logic [2:0] T_JALR   = 3'd6;

  localparam logic [1:0] E_ILLEGAL = 2'd1;
  localparam logic [1:0] E_RANGE   = 2'd2;

  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]           wr_data_q, wr_data_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [1:0]            err_code_q, err_code_d;

  logic        full;
  logic        accept;
  logic        illegal;
  logic        bad_imm;
  logic [31:0] enc;
  logic [31:0] imm;
  logic        fits12, fits13, fits21;

  assign full   = (cnt_q == MAXW);
  assign accept = bus.in_valid & bus.in_ready;
  assign imm    = bus.in_imm;

  // Sign-extension tests: upper bits must all equal the top bit of the field.
  assign fits12 = (imm[31:11] == {21{imm[11]}});
  assign fits13 = (imm[31:12] == {20{imm[12]}});
  assign fits21 = (imm[31:20] == {12{imm[20]}});

  always_comb begin
    enc     = '0;
    illegal = 1'b0;
    bad_imm = 1'b0;
    case (bus.in_type)
      T_R: enc = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, 7'b0110011};
      T_IALU: begin
        enc     = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, 7'b0010011};
        bad_imm = !fits12;
      end
      T_LOAD: begin
        enc     = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, 7'b0000011};
        bad_imm = !fits12;
      end
      T_JALR: begin
        enc     = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, 7'b1100111};
        bad_imm = !fits12;
      end
      T_STORE: begin
        enc     = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0], 7'b0100011};
        bad_imm = !fits12;
      end
      T_BRANCH: begin
        enc     = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                   imm[4:1], imm[11], 7'b1100011};
        bad_imm = !fits13 || imm[0];
      end
      T_JAL: begin
        enc     = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, 7'b1101111};
        bad_imm = !fits21 || imm[0];
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    wr_en_d    = 1'b0;
    err_d      = 1'b0;
    err_code_d = 2'd0;
    wr_data_d  = wr_data_q;
    wr_addr_d  = wr_addr_q;
    cnt_d      = cnt_q;
    // start wins over any request presented in the same cycle
    if (bus.start) begin
      cnt_d     = '0;
      wr_addr_d = BASE;
    end else if (accept) begin
      if (illegal) begin
        err_d      = 1'b1;
        err_code_d = E_ILLEGAL;
      end else if (bad_imm) begin
        err_d      = 1'b1;
        err_code_d = E_RANGE;
      end else begin
        wr_en_d   = 1'b1;
        wr_data_d = enc;
        wr_addr_d = BASE + cnt_q[ADDR_WIDTH-1:0];
        cnt_d     = cnt_q + (ADDR_WIDTH+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_en_q    <= 1'b0;
      wr_addr_q  <= BASE;
      wr_data_q  <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign bus.in_ready   = rstn & ~bus.start & ~full;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.word_count = cnt_q;
  assign bus.full       = full;
  assign bus.err        = err_q;
  assign bus.err_code   = err_code_q;

endmodule
